// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file access controller.
// Holds the controller state encoding, default geometry and the read-modify-write merge.
package regfile_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;
  localparam int DEPTH      = 2**ADDR_W_DEF;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_CAP,
    WR,
    RSP,
    CLR
  } state_t;

  function automatic logic [DATA_W_DEF-1:0] merge_bits(
    input logic [DATA_W_DEF-1:0] old_w,
    input logic [DATA_W_DEF-1:0] new_w,
    input logic [DATA_W_DEF-1:0] mask
  );
    return (old_w & ~mask) | (new_w & mask);
  endfunction

endpackage

// File: rtl/regfile_access_ctrl.sv
// Initiator-side controller for a 4x8 single-port register RAM: valid/ready
// read, write and masked (read-modify-write) requests plus a zero-fill sweep.
//
// state  | meaning
// IDLE   | waiting for a request or a clear pulse
// RD     | RAM read issued at addr_q
// RD_CAP | RAM data available; capture for read or merge for masked write
// WR     | RAM write of wdata_q at addr_q
// RSP    | response presented until rsp_ready
// CLR    | zero-fill sweep, one entry per cycle
module regfile_access_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit RMW_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic              ram_reset,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(2**ADDR_W - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W:0]   clr_cnt;
  logic              accept;
  logic              full_word;

  assign req_ready = reset_n && (state_q == IDLE) && !clr_start;
  assign accept    = req_valid && req_ready;
  assign full_word = (req_wmask == '1) || !RMW_EN;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clr_start)   state_d = CLR;
        else if (accept) state_d = (req_we && full_word) ? WR : RD;
      end
      RD:      state_d = RD_CAP;
      RD_CAP:  state_d = (we_q && (mask_q != '0)) ? WR : RSP;
      WR:      state_d = RSP;
      RSP:     if (rsp_ready) state_d = IDLE;
      CLR:     if (clr_cnt == CNT_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      clr_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          clr_cnt <= '0;
          if (accept) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            mask_q  <= RMW_EN ? req_wmask : '1;
          end
        end
        RD_CAP: begin
          // an all-zero mask writes nothing, so the old word is the response
          if (we_q && (mask_q != '0)) wdata_q <= merge_bits(ram_dout, wdata_q, mask_q);
          else                        rdata_q <= ram_dout;
        end
        WR:      rdata_q <= wdata_q;
        CLR:     clr_cnt <= clr_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    ram_ce  = 1'b0;
    ram_wre = 1'b0;
    ram_ad  = '0;
    ram_din = '0;
    if (reset_n) begin
      case (state_q)
        RD: begin
          ram_ce = 1'b1;
          ram_ad = addr_q;
        end
        WR: begin
          ram_ce  = 1'b1;
          ram_wre = 1'b1;
          ram_ad  = addr_q;
          ram_din = wdata_q;
        end
        CLR: begin
          ram_ce  = 1'b1;
          ram_wre = 1'b1;
          ram_ad  = clr_cnt[ADDR_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign ram_oce   = ram_ce;
  assign ram_reset = ~reset_n;
  assign rsp_valid = reset_n && (state_q == RSP);
  assign clr_busy  = reset_n && (state_q == CLR);
  assign rsp_rdata = reset_n ? rdata_q : '0;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench: instance 0 with read-modify-write enabled, instance 1 with it disabled,
// each attached to a behavioural model of the single-port register RAM.
module tb_regfile_access_ctrl;

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         lat;
    int         acc;
  } exp_t;

  typedef struct {
    int         inst;
    logic [1:0] ad;
    logic [7:0] din;
    int         cyc;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_we    [2];
  logic [1:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic [7:0] req_wmask [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_rdata [2];
  logic       clr_start [2];
  logic       clr_busy  [2];
  logic       ram_ce    [2];
  logic       ram_oce   [2];
  logic       ram_wre   [2];
  logic       ram_reset [2];
  logic [1:0] ram_ad    [2];
  logic [7:0] ram_din   [2];
  logic [7:0] ram_dout  [2];

  logic [7:0] mem [2][4];

  exp_t sb[$];
  wr_t  wr_log[$];
  int   rd_cnt [2];
  int   busy_cnt;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   in_rsp [2];
  logic [7:0] held [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_access_ctrl #(.DATA_W(8), .ADDR_W(2), .RMW_EN(1'b1)) u_rmw (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .clr_start(clr_start[0]), .clr_busy(clr_busy[0]),
    .ram_ce(ram_ce[0]), .ram_oce(ram_oce[0]), .ram_wre(ram_wre[0]), .ram_reset(ram_reset[0]),
    .ram_ad(ram_ad[0]), .ram_din(ram_din[0]), .ram_dout(ram_dout[0])
  );

  regfile_access_ctrl #(.DATA_W(8), .ADDR_W(2), .RMW_EN(1'b0)) u_plain (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .clr_start(clr_start[1]), .clr_busy(clr_busy[1]),
    .ram_ce(ram_ce[1]), .ram_oce(ram_oce[1]), .ram_wre(ram_wre[1]), .ram_reset(ram_reset[1]),
    .ram_ad(ram_ad[1]), .ram_din(ram_din[1]), .ram_dout(ram_dout[1])
  );

  // RAM model: bypass read, dout unchanged on write, synchronous output reset
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ram_reset[k]) ram_dout[k] <= 8'h00;
      else if (ram_ce[k]) begin
        if (ram_wre[k]) mem[k][ram_ad[k]] <= ram_din[k];
        else            ram_dout[k] <= mem[k][ram_ad[k]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: scoreboard pop on the first cycle of each response, hold check after
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("oce_eq_ce", {31'd0, ram_oce[k]}, {31'd0, ram_ce[k]});
      chk("ram_reset", {31'd0, ram_reset[k]}, {31'd0, ~reset_n});
      if (ram_ce[k] && ram_wre[k]) wr_log.push_back('{k, ram_ad[k], ram_din[k], cyc});
      if (ram_ce[k] && !ram_wre[k]) rd_cnt[k]++;
      if (k == 0 && clr_busy[0]) busy_cnt++;
      if (rsp_valid[k]) begin
        chk("ready_low_in_rsp", {31'd0, req_ready[k]}, 32'd0);
        if (!in_rsp[k]) begin
          if (sb.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
          else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_inst", k, e.inst);
            chk("rsp_rdata", {24'd0, rsp_rdata[k]}, {24'd0, e.data});
            chk("rsp_latency", cyc - e.acc, e.lat);
          end
          held[k]   = rsp_rdata[k];
          in_rsp[k] = 1'b1;
        end else begin
          chk("rsp_hold", {24'd0, rsp_rdata[k]}, {24'd0, held[k]});
        end
        if (rsp_ready[k]) in_rsp[k] = 1'b0;
      end else begin
        in_rsp[k] = 1'b0;
      end
    end
  end

  // called #1 after a rising edge; returns #1 after the edge that accepted the request
  task automatic do_req(input int k, input logic we, input logic [1:0] a, input logic [7:0] d,
                        input logic [7:0] m, input logic [7:0] exp_d, input int lat);
    bit done = 1'b0;
    req_we[k] = we; req_addr[k] = a; req_wdata[k] = d; req_wmask[k] = m;
    req_valid[k] = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (req_ready[k]) begin
        sb.push_back('{k, exp_d, lat, cyc});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid[k] = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid[0] && !rsp_valid[1]) done = 1'b1;
    end
    @(posedge clk); #1;
    if (!done) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_cnt[0] = 0; rd_cnt[1] = 0;
    busy_cnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 4; a++) mem[k][a] = 8'h00;
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = 2'd0;
      req_wdata[k] = 8'h00; req_wmask[k] = 8'h00; rsp_ready[k] = 1'b1;
      clr_start[k] = 1'b0; in_rsp[k] = 1'b0; held[k] = 8'h00; rd_cnt[k] = 0;
    end
    busy_cnt = 0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_req_ready", {31'd0, req_ready[k]}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
      chk("rst_rsp_rdata", {24'd0, rsp_rdata[k]}, 32'd0);
      chk("rst_clr_busy", {31'd0, clr_busy[k]}, 32'd0);
      chk("rst_ram_ce", {31'd0, ram_ce[k]}, 32'd0);
      chk("rst_ram_wre", {31'd0, ram_wre[k]}, 32'd0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // full write then read back
    clear_logs();
    do_req(0, 1'b1, 2'd2, 8'hA5, 8'hFF, 8'hA5, 2);
    wait_done();
    chk("fw_wr_count", wr_log.size(), 1);
    if (wr_log.size() == 1) begin
      chk("fw_wr_ad", {30'd0, wr_log[0].ad}, 32'd2);
      chk("fw_wr_din", {24'd0, wr_log[0].din}, 32'hA5);
    end
    chk("fw_no_read", rd_cnt[0], 0);
    do_req(0, 1'b0, 2'd2, 8'h00, 8'h00, 8'hA5, 3);
    wait_done();

    // masked write as read-modify-write
    do_req(0, 1'b1, 2'd1, 8'h3C, 8'hFF, 8'h3C, 2);
    wait_done();
    clear_logs();
    do_req(0, 1'b1, 2'd1, 8'hFF, 8'h0F, 8'h3F, 4);
    wait_done();
    chk("mw_rd_count", rd_cnt[0], 1);
    chk("mw_wr_count", wr_log.size(), 1);
    if (wr_log.size() == 1) begin
      chk("mw_wr_ad", {30'd0, wr_log[0].ad}, 32'd1);
      chk("mw_wr_din", {24'd0, wr_log[0].din}, 32'h3F);
    end
    do_req(0, 1'b0, 2'd1, 8'h00, 8'h00, 8'h3F, 3);
    wait_done();

    // zero mask: old word returned, nothing written
    clear_logs();
    do_req(0, 1'b1, 2'd1, 8'h00, 8'h00, 8'h3F, 3);
    wait_done();
    chk("zm_wr_count", wr_log.size(), 0);

    // response back-pressure
    do_req(0, 1'b1, 2'd3, 8'h5A, 8'hFF, 8'h5A, 2);
    wait_done();
    rsp_ready[0] = 1'b0;
    do_req(0, 1'b0, 2'd3, 8'h00, 8'h00, 8'h5A, 3);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) seen = 1'b1;
    end
    chk("bp_rsp_seen", {31'd0, seen}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid_held", {31'd0, rsp_valid[0]}, 32'd1);
    end
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_valid_at_hs", {31'd0, rsp_valid[0]}, 32'd1);
    @(negedge clk);
    chk("bp_valid_after", {31'd0, rsp_valid[0]}, 32'd0);
    chk("bp_idle_ready", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk); #1;

    // clear wins over a simultaneous read
    do_req(0, 1'b1, 2'd0, 8'h11, 8'hFF, 8'h11, 2);
    wait_done();
    do_req(0, 1'b1, 2'd2, 8'h22, 8'hFF, 8'h22, 2);
    wait_done();
    clear_logs();
    clr_start[0] = 1'b1;
    req_we[0] = 1'b0; req_addr[0] = 2'd2; req_valid[0] = 1'b1;
    @(negedge clk);
    chk("clr_blocks_ready", {31'd0, req_ready[0]}, 32'd0);
    @(posedge clk); #1;
    clr_start[0] = 1'b0;
    do_req(0, 1'b0, 2'd2, 8'h00, 8'h00, 8'h00, 3);
    wait_done();
    chk("clr_busy_cycles", busy_cnt, 4);
    chk("clr_wr_count", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("clr_ad", {30'd0, wr_log[i].ad}, i);
        chk("clr_din", {24'd0, wr_log[i].din}, 32'd0);
        chk("clr_consecutive", wr_log[i].cyc - wr_log[0].cyc, i);
      end
    end

    // reset during RD_CAP of a masked write
    clear_logs();
    req_we[0] = 1'b1; req_addr[0] = 2'd0; req_wdata[0] = 8'hFF; req_wmask[0] = 8'h0F;
    req_valid[0] = 1'b1;
    @(negedge clk);
    chk("rr_accept", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("rr_rd_ce", {31'd0, ram_ce[0]}, 32'd1);
    chk("rr_rd_wre", {31'd0, ram_wre[0]}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("rr_ram_reset", {31'd0, ram_reset[0]}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rr_req_ready", {31'd0, req_ready[0]}, 32'd0);
    chk("rr_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("rr_rsp_rdata", {24'd0, rsp_rdata[0]}, 32'd0);
    chk("rr_clr_busy", {31'd0, clr_busy[0]}, 32'd0);
    chk("rr_ram_ce", {31'd0, ram_ce[0]}, 32'd0);
    chk("rr_ram_ad", {30'd0, ram_ad[0]}, 32'd0);
    chk("rr_ram_din", {24'd0, ram_din[0]}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rr_no_write", wr_log.size(), 0);
    do_req(0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 3);
    wait_done();

    // mask ignored when read-modify-write is disabled
    clear_logs();
    do_req(1, 1'b1, 2'd0, 8'h12, 8'h01, 8'h12, 2);
    wait_done();
    chk("nr_no_read", rd_cnt[1], 0);
    chk("nr_wr_count", wr_log.size(), 1);
    if (wr_log.size() == 1) begin
      chk("nr_wr_inst", wr_log[0].inst, 1);
      chk("nr_wr_din", {24'd0, wr_log[0].din}, 32'h12);
    end
    do_req(1, 1'b0, 2'd0, 8'h00, 8'h00, 8'h12, 3);
    wait_done();

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
